// File: rtl/cu_l2_arb_pkg.sv
// Shared source encodings and request layout for the compute-unit L2 request arbiter.
package cu_l2_arb_pkg;

  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  localparam int L2_ADDR_WIDTH = 26;
  localparam int L2_DATA_WIDTH = 512;
  localparam int L2_ITAG_WIDTH = 8;
  localparam int L2_DTAG_WIDTH = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int L2_OTAG_WIDTH = max_int(L2_ITAG_WIDTH, L2_DTAG_WIDTH) + 1;

  typedef struct packed {
    logic                         rw;
    logic [L2_DATA_WIDTH/8-1:0]   byteen;
    logic [L2_ADDR_WIDTH-1:0]     addr;
    logic [L2_DATA_WIDTH-1:0]     data;
    logic [L2_OTAG_WIDTH-1:0]     tag;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; pointer names the stream favoured on the next conflict.
module rr_arb2
  import cu_l2_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr == SRC_DATA) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr <= SRC_INSTR;
    end else if (en && (gnt != 2'b00)) begin
      rr <= gnt[SRC_DATA] ? SRC_INSTR : SRC_DATA;
    end
  end

endmodule

// File: rtl/cu_l2_req_arbiter.sv
// Merges instruction/data L2 request streams into one registered port and routes responses back.
module cu_l2_req_arbiter
  import cu_l2_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH      = L2_ADDR_WIDTH,
  parameter  int DATA_WIDTH      = L2_DATA_WIDTH,
  parameter  int ITAG_WIDTH      = L2_ITAG_WIDTH,
  parameter  int DTAG_WIDTH      = L2_DTAG_WIDTH,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int OTAG_WIDTH      = max_int(ITAG_WIDTH, DTAG_WIDTH) + 1,
  localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic                    i_req_rw,
  input  logic [DATA_WIDTH/8-1:0] i_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [ITAG_WIDTH-1:0]   i_req_tag,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_rw,
  input  logic [DATA_WIDTH/8-1:0] d_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_data,
  input  logic [DTAG_WIDTH-1:0]   d_req_tag,
  output logic                    o_req_valid,
  input  logic                    o_req_ready,
  output logic                    o_req_rw,
  output logic [DATA_WIDTH/8-1:0] o_req_byteen,
  output logic [ADDR_WIDTH-1:0]   o_req_addr,
  output logic [DATA_WIDTH-1:0]   o_req_data,
  output logic [OTAG_WIDTH-1:0]   o_req_tag,
  input  logic                    o_rsp_valid,
  output logic                    o_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   o_rsp_data,
  input  logic [OTAG_WIDTH-1:0]   o_rsp_tag,
  output logic                    i_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   i_rsp_data,
  output logic [ITAG_WIDTH-1:0]   i_rsp_tag,
  output logic                    d_rsp_valid,
  input  logic                    d_rsp_ready,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic [DTAG_WIDTH-1:0]   d_rsp_tag,
  output logic                    idle_o
);

  typedef struct packed {
    logic                    rw;
    logic [DATA_WIDTH/8-1:0] byteen;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [OTAG_WIDTH-1:0]   tag;
  } req_t;

  req_t                 req_q, req_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           gnt;
  logic                 load_en, room, i_elig, d_elig;
  logic                 req_rd_hs, rsp_hs, rsp_ok, rsp_to_data;

  assign load_en = !o_req_valid || o_req_ready;

  // A read sitting in the output register already owns a slot, so it counts against the limit.
  assign room = ({1'b0, cnt} + (CNT_WIDTH+1)'(o_req_valid && !req_q.rw))
                < (CNT_WIDTH+1)'(MAX_OUTSTANDING);

  assign i_elig = i_req_valid && (i_req_rw || room);
  assign d_elig = d_req_valid && (d_req_rw || room);

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({d_elig, i_elig}),
    .en    (load_en),
    .gnt   (gnt)
  );

  assign i_req_ready = load_en && gnt[SRC_INSTR] && !rst_i;
  assign d_req_ready = load_en && gnt[SRC_DATA]  && !rst_i;

  always_comb begin
    req_d = '0;
    if (gnt[SRC_DATA]) begin
      req_d.rw     = d_req_rw;
      req_d.byteen = d_req_byteen;
      req_d.addr   = d_req_addr;
      req_d.data   = d_req_data;
      req_d.tag    = {SRC_DATA, (OTAG_WIDTH-1)'(d_req_tag)};
    end else begin
      req_d.rw     = i_req_rw;
      req_d.byteen = i_req_byteen;
      req_d.addr   = i_req_addr;
      req_d.data   = i_req_data;
      req_d.tag    = {SRC_INSTR, (OTAG_WIDTH-1)'(i_req_tag)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_req_valid <= 1'b0;
    end else if (load_en) begin
      o_req_valid <= (gnt != 2'b00);
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_en && (gnt != 2'b00)) begin
      req_q <= req_d;
    end
  end

  assign o_req_rw     = req_q.rw;
  assign o_req_byteen = req_q.byteen;
  assign o_req_addr   = req_q.addr;
  assign o_req_data   = req_q.data;
  assign o_req_tag    = req_q.tag;

  assign req_rd_hs = o_req_valid && o_req_ready && !req_q.rw;
  assign rsp_hs    = o_rsp_valid && o_rsp_ready;
  assign rsp_ok    = rsp_hs && (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      case ({req_rd_hs, rsp_ok})
        2'b10:   if (cnt != CNT_WIDTH'(MAX_OUTSTANDING)) cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  rsp_without_read: assert property (@(posedge clk_i) disable iff (rst_i) rsp_hs |-> cnt != '0);

  assign rsp_to_data = o_rsp_tag[OTAG_WIDTH-1];
  assign i_rsp_valid = o_rsp_valid && !rsp_to_data;
  assign d_rsp_valid = o_rsp_valid &&  rsp_to_data;
  assign o_rsp_ready = !rst_i && (rsp_to_data ? d_rsp_ready : i_rsp_ready);
  assign i_rsp_data  = o_rsp_data;
  assign d_rsp_data  = o_rsp_data;
  assign i_rsp_tag   = o_rsp_tag[ITAG_WIDTH-1:0];
  assign d_rsp_tag   = o_rsp_tag[DTAG_WIDTH-1:0];

  assign idle_o = !o_req_valid && (cnt == '0) && !i_req_valid && !d_req_valid;

endmodule

// File: tb/tb_cu_l2_req_arbiter.sv
// Directed bench for cu_l2_req_arbiter: default instance plus a MAX_OUTSTANDING=2 instance.
module tb_cu_l2_req_arbiter;

  localparam int AW = 26;
  localparam int DW = 512;
  localparam int IW = 8;
  localparam int TW = 10;
  localparam int OW = 11;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            i_req_valid, i_req_rw, d_req_valid, d_req_rw;
  logic [DW/8-1:0] i_req_byteen, d_req_byteen;
  logic [AW-1:0]   i_req_addr, d_req_addr;
  logic [DW-1:0]   i_req_data, d_req_data;
  logic [IW-1:0]   i_req_tag;
  logic [TW-1:0]   d_req_tag;
  logic            o_req_ready, o_rsp_valid, o_rsp_valid_b, i_rsp_ready, d_rsp_ready;
  logic [DW-1:0]   o_rsp_data;
  logic [OW-1:0]   o_rsp_tag;

  logic            i_req_ready, d_req_ready, o_req_valid, o_req_rw, o_rsp_ready;
  logic [DW/8-1:0] o_req_byteen;
  logic [AW-1:0]   o_req_addr;
  logic [DW-1:0]   o_req_data, i_rsp_data, d_rsp_data;
  logic [OW-1:0]   o_req_tag;
  logic            i_rsp_valid, d_rsp_valid, idle_o;
  logic [IW-1:0]   i_rsp_tag;
  logic [TW-1:0]   d_rsp_tag;

  logic            i_req_ready_b, d_req_ready_b, o_req_valid_b, o_req_rw_b, o_rsp_ready_b;
  logic [DW/8-1:0] o_req_byteen_b;
  logic [AW-1:0]   o_req_addr_b;
  logic [DW-1:0]   o_req_data_b, i_rsp_data_b, d_rsp_data_b;
  logic [OW-1:0]   o_req_tag_b;
  logic            i_rsp_valid_b, d_rsp_valid_b, idle_b;
  logic [IW-1:0]   i_rsp_tag_b;
  logic [TW-1:0]   d_rsp_tag_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  cu_l2_req_arbiter u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_rw(i_req_rw),
    .i_req_byteen(i_req_byteen), .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_tag(i_req_tag),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_rw(d_req_rw),
    .d_req_byteen(d_req_byteen), .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_tag(d_req_tag),
    .o_req_valid(o_req_valid), .o_req_ready(o_req_ready), .o_req_rw(o_req_rw),
    .o_req_byteen(o_req_byteen), .o_req_addr(o_req_addr), .o_req_data(o_req_data), .o_req_tag(o_req_tag),
    .o_rsp_valid(o_rsp_valid), .o_rsp_ready(o_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_tag(i_rsp_tag),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_tag(d_rsp_tag),
    .idle_o(idle_o)
  );

  cu_l2_req_arbiter #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready_b), .i_req_rw(i_req_rw),
    .i_req_byteen(i_req_byteen), .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_tag(i_req_tag),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready_b), .d_req_rw(d_req_rw),
    .d_req_byteen(d_req_byteen), .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_tag(d_req_tag),
    .o_req_valid(o_req_valid_b), .o_req_ready(o_req_ready), .o_req_rw(o_req_rw_b),
    .o_req_byteen(o_req_byteen_b), .o_req_addr(o_req_addr_b), .o_req_data(o_req_data_b), .o_req_tag(o_req_tag_b),
    .o_rsp_valid(o_rsp_valid_b), .o_rsp_ready(o_rsp_ready_b), .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag),
    .i_rsp_valid(i_rsp_valid_b), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data_b), .i_rsp_tag(i_rsp_tag_b),
    .d_rsp_valid(d_rsp_valid_b), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data_b), .d_rsp_tag(d_rsp_tag_b),
    .idle_o(idle_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset with traffic presented: nothing may be accepted.
    rst_i = 1'b1;
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_byteen = '1; i_req_addr = '0; i_req_data = '0; i_req_tag = '0;
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_byteen = '1; d_req_addr = '0; d_req_data = '0; d_req_tag = '0;
    o_req_ready = 1'b1; o_rsp_valid = 1'b1; o_rsp_valid_b = 1'b0; o_rsp_data = '0; o_rsp_tag = '0;
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    tick();
    check("rst_i_ready",   64'(i_req_ready), 64'd0);
    check("rst_d_ready",   64'(d_req_ready), 64'd0);
    check("rst_rsp_ready", 64'(o_rsp_ready), 64'd0);
    check("rst_o_valid",   64'(o_req_valid), 64'd0);
    check("rst_idle_busy", 64'(idle_o),      64'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0; o_rsp_valid = 1'b0;
    settle();
    check("rst_idle", 64'(idle_o), 64'd1);
    tick();
    rst_i = 1'b0;

    // Single instruction read.
    i_req_valid = 1'b1; i_req_addr = 26'h100; i_req_tag = 8'h05; i_req_data = 512'hA;
    settle();
    check("t1_i_ready", 64'(i_req_ready), 64'd1);
    check("t1_d_ready", 64'(d_req_ready), 64'd0);
    tick();
    i_req_valid = 1'b0;
    settle();
    check("t1_o_valid", 64'(o_req_valid), 64'd1);
    check("t1_o_addr",  64'(o_req_addr),  64'h100);
    check("t1_o_tag",   64'(o_req_tag),   64'h005);
    check("t1_o_rw",    64'(o_req_rw),    64'd0);
    check("t1_o_data",  64'(o_req_data[63:0]), 64'hA);
    tick();
    check("t1_cnt",     64'(u_dut.cnt),   64'd1);
    check("t1_o_empty", 64'(o_req_valid), 64'd0);
    check("t1_idle",    64'(idle_o),      64'd0);

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    // Both streams reading: I,D,I,D.
    i_req_valid = 1'b1; i_req_addr = 26'h200; i_req_tag = 8'h01;
    d_req_valid = 1'b1; d_req_addr = 26'h300; d_req_tag = 10'h002;
    settle();
    check("t2_first_i_ready", 64'(i_req_ready), 64'd1);
    check("t2_first_d_ready", 64'(d_req_ready), 64'd0);
    tick();
    check("t2_g0_valid", 64'(o_req_valid), 64'd1);
    check("t2_g0_tag",   64'(o_req_tag),   64'h001);
    check("t2_g1_d_ready", 64'(d_req_ready), 64'd1);
    tick();
    check("t2_g1_tag",   64'(o_req_tag),   64'h402);
    tick();
    check("t2_g2_tag",   64'(o_req_tag),   64'h001);
    tick();
    check("t2_g3_tag",   64'(o_req_tag),   64'h402);
    check("t2_g3_addr",  64'(o_req_addr),  64'h300);
    check("t2_cnt",      64'(u_dut.cnt),   64'd3);

    // Back-pressure: buffered data request must hold for 5 cycles.
    o_req_ready = 1'b0;
    i_req_addr = 26'h210; i_req_tag = 8'h03;
    d_req_addr = 26'h310; d_req_tag = 10'h004;
    settle();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid",   64'(o_req_valid), 64'd1);
      check("t3_hold_addr",    64'(o_req_addr),  64'h300);
      check("t3_hold_tag",     64'(o_req_tag),   64'h402);
      check("t3_hold_i_ready", 64'(i_req_ready), 64'd0);
      check("t3_hold_d_ready", 64'(d_req_ready), 64'd0);
      tick();
    end
    check("t3_hold_cnt", 64'(u_dut.cnt), 64'd3);
    d_req_valid = 1'b0; o_req_ready = 1'b1;
    settle();
    check("t3_rel_i_ready", 64'(i_req_ready), 64'd1);
    tick();
    i_req_valid = 1'b0;
    check("t3_next_tag",  64'(o_req_tag),  64'h003);
    check("t3_next_addr", 64'(o_req_addr), 64'h210);
    check("t3_cnt_a",     64'(u_dut.cnt),  64'd4);
    tick();
    check("t3_no_dup",    64'(o_req_valid), 64'd0);
    check("t3_cnt_b",     64'(u_dut.cnt),   64'd5);

    // Response routing to data stream with back-pressure.
    o_rsp_valid = 1'b1; o_rsp_tag = 11'h43A; o_rsp_data = 512'h5A5A;
    i_rsp_ready = 1'b1; d_rsp_ready = 1'b0;
    settle();
    check("t4_d_rsp_valid", 64'(d_rsp_valid), 64'd1);
    check("t4_i_rsp_valid", 64'(i_rsp_valid), 64'd0);
    check("t4_rsp_ready_0", 64'(o_rsp_ready), 64'd0);
    check("t4_d_rsp_tag",   64'(d_rsp_tag),   64'h03A);
    check("t4_d_rsp_data",  64'(d_rsp_data[63:0]), 64'h5A5A);
    tick();
    check("t4_cnt_stall", 64'(u_dut.cnt), 64'd5);
    d_rsp_ready = 1'b1;
    settle();
    check("t4_rsp_ready_1", 64'(o_rsp_ready), 64'd1);
    tick();
    check("t4_cnt_dec", 64'(u_dut.cnt), 64'd4);
    o_rsp_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 26'h220; i_req_tag = 8'h06;
    tick();
    i_req_valid = 1'b0; o_rsp_valid = 1'b1;
    check("t4_cnt_loaded", 64'(u_dut.cnt), 64'd4);
    tick();
    check("t4_cnt_same",   64'(u_dut.cnt),  64'd4);
    check("t4_req_gone",   64'(o_req_valid), 64'd0);
    o_rsp_tag = 11'h012; i_rsp_ready = 1'b0;
    settle();
    check("t4_i_rsp_valid_b", 64'(i_rsp_valid), 64'd1);
    check("t4_d_rsp_valid_b", 64'(d_rsp_valid), 64'd0);
    check("t4_i_rsp_ready_0", 64'(o_rsp_ready), 64'd0);
    check("t4_i_rsp_tag",     64'(i_rsp_tag),   64'h12);
    i_rsp_ready = 1'b1;
    tick();
    o_rsp_valid = 1'b0;
    check("t4_cnt_three", 64'(u_dut.cnt), 64'd3);

    // Reset with a buffered request and three reads outstanding.
    i_req_valid = 1'b1; i_req_addr = 26'h230; i_req_tag = 8'h08; o_req_ready = 1'b0;
    tick();
    i_req_valid = 1'b0;
    check("t5_buffered", 64'(o_req_valid),     64'd1);
    check("t5_cnt_pre",  64'(u_dut.cnt),       64'd3);
    check("t5_rr_pre",   64'(u_dut.u_arb.rr),  64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    check("t5_o_valid", 64'(o_req_valid),    64'd0);
    check("t5_cnt",     64'(u_dut.cnt),      64'd0);
    check("t5_rr",      64'(u_dut.u_arb.rr), 64'd0);
    check("t5_idle",    64'(idle_o),         64'd1);

    // MAX_OUTSTANDING=2: third read stalls, write still passes, response releases it.
    o_req_ready = 1'b1;
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 26'h400; i_req_tag = 8'h07;
    settle();
    check("t6_ready_first", 64'(i_req_ready_b), 64'd1);
    tick();
    tick();
    check("t6_cnt_one",   64'(u_dut2.cnt),    64'd1);
    check("t6_read_stall", 64'(i_req_ready_b), 64'd0);
    d_req_valid = 1'b1; d_req_rw = 1'b1; d_req_addr = 26'h500; d_req_tag = 10'h009;
    settle();
    check("t6_write_ready", 64'(d_req_ready_b), 64'd1);
    tick();
    d_req_valid = 1'b0;
    check("t6_write_rw",  64'(o_req_rw_b),  64'd1);
    check("t6_write_tag", 64'(o_req_tag_b), 64'h409);
    check("t6_cnt_two",   64'(u_dut2.cnt),  64'd2);
    check("t6_stall_b",   64'(i_req_ready_b), 64'd0);
    tick();
    check("t6_write_gone", 64'(o_req_valid_b), 64'd0);
    check("t6_cnt_write",  64'(u_dut2.cnt),    64'd2);
    check("t6_stall_c",    64'(i_req_ready_b), 64'd0);
    o_rsp_valid_b = 1'b1; o_rsp_tag = 11'h007; i_rsp_ready = 1'b1;
    settle();
    check("t6_rsp_ready", 64'(o_rsp_ready_b), 64'd1);
    check("t6_rsp_i",     64'(i_rsp_valid_b), 64'd1);
    tick();
    o_rsp_valid_b = 1'b0;
    settle();
    check("t6_cnt_rsp",    64'(u_dut2.cnt),    64'd1);
    check("t6_read_again", 64'(i_req_ready_b), 64'd1);
    tick();
    i_req_valid = 1'b0;
    check("t6_read_valid", 64'(o_req_valid_b), 64'd1);
    check("t6_read_tag",   64'(o_req_tag_b),   64'h007);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_l2_req_arbiter.md
Name: cu_l2_req_arbiter

Overview:
- Sits directly downstream of the compute unit. Merges its two L2-side memory request streams (L1 instruction-cache misses and L1 data-cache misses) into a single request port toward the shared L2 cache.
- Routes L2 responses back to the originating stream.
- Tracks outstanding reads and reports an idle indication used by the sleep/power controller together with the compute unit's sleep request.

Parameters:
- ADDR_WIDTH, 26, line address width (64-byte lines).
- DATA_WIDTH, 512, line data width in bits.
- ITAG_WIDTH, 8, instruction-stream tag width.
- DTAG_WIDTH, 10, data-stream tag width.
- MAX_OUTSTANDING, 16, maximum reads in flight to L2 (≥1).
- Derived OTAG_WIDTH = max(ITAG_WIDTH, DTAG_WIDTH) + 1; CNT_WIDTH = $clog2(MAX_OUTSTANDING+1).

Ports:
Interface: one clock, clk_i; reset is synchronous and active-high, rst_i. All ports listed as name, direction, width, meaning.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- i_req_valid / i_req_ready  in / out  1  instruction request handshake.
- i_req_rw  in  1  instruction request, 1 = write.
- i_req_byteen  in  DATA_WIDTH/8  instruction request byte enables.
- i_req_addr  in  ADDR_WIDTH  instruction request address.
- i_req_data  in  DATA_WIDTH  instruction request write data.
- i_req_tag  in  ITAG_WIDTH  instruction request tag.
- d_req_*  same set as i_req_*, tag width DTAG_WIDTH.
- o_req_valid / o_req_ready  out / in  1  L2 request handshake.
- o_req_rw, o_req_byteen, o_req_addr, o_req_data  out  widths as above.
- o_req_tag  out  OTAG_WIDTH  {src, zero-extended source tag}; src 0 = instruction, 1 = data.
- o_rsp_valid / o_rsp_ready  in / out  1  L2 response handshake.
- o_rsp_data  in  DATA_WIDTH  L2 response data.
- o_rsp_tag  in  OTAG_WIDTH  L2 response tag.
- i_rsp_valid / i_rsp_ready  out / in  1  instruction response handshake.
- i_rsp_data  out  DATA_WIDTH  instruction response data.
- i_rsp_tag  out  ITAG_WIDTH  instruction response tag.
- d_rsp_*  same set as i_rsp_*, tag width DTAG_WIDTH.
- idle_o  out  1  no buffered request, no outstanding read, no pending input.

Behaviour:
- Request path uses a single output register.
  - Register loads when empty or o_req_ready=1 (load_en = !o_req_valid | o_req_ready).
  - Full throughput. Fixed latency: 1 cycle from input handshake to o_req_valid.
- Eligibility: a stream is eligible when its valid=1 and, if rw=0, (cnt + pending_read_in_reg) < MAX_OUTSTANDING. Writes are never throttled.
- Arbitration is round-robin via 1-bit pointer rr (0 = instruction priority).
  - Only one eligible stream: it wins.
  - Both eligible: the stream named by rr wins.
  - After any grant, rr = !winner.
  - x_req_ready = load_en & granted_x; the ready of the non-granted stream is 0.
- Outstanding counter cnt increments on an o_req handshake with rw=0. It decrements on an o_rsp handshake.
  - Both in the same cycle: cnt is unchanged.
  - Writes produce no response and never touch cnt.
  - Counter never wraps. An o_rsp with cnt=0 is a protocol error: ignore the decrement and flag an assertion.
- Response path is combinational, with no storage.
  - o_rsp_tag MSB selects the destination: i_rsp_valid = o_rsp_valid & !msb; d_rsp_valid = o_rsp_valid & msb.
  - o_rsp_ready = ready of the selected destination.
  - Data is broadcast to both destinations. Tags are the low ITAG_WIDTH / DTAG_WIDTH bits.
- idle_o = !o_req_valid & cnt==0 & !i_req_valid & !d_req_valid. It is combinational from registered state plus inputs.
- Reset values:
  - o_req_valid=0, rr=0, cnt=0.
  - idle_o follows its equation: 1 if both input valids are low.
  - All ready outputs are 0 while rst_i=1, including o_rsp_ready.
- Reset mid-operation: the buffered request is dropped and cnt cleared. Responses presented during reset are not accepted.
- o_req payload is held stable while o_req_valid=1 and o_req_ready=0 (valid/ready protocol; no retraction).

Decomposition:
- Package cu_l2_arb_pkg holds:
  - localparam SRC_INSTR=1'b0 and SRC_DATA=1'b1;
  - mem_req_t struct {rw, byteen, addr, data, tag}, parameterised via package localparams matching e_gpu.vh cache line/tag widths.
- One natural sub-module: rr_arb2, the 2-input round-robin arbiter (request vector, grant one-hot, pointer update on grant enable).

Test Plan:
- Only i_req_valid, read addr 0x100, tag 0x05, o_req_ready=1 → next cycle o_req_valid=1, addr 0x100, o_req_tag={0,0x005}; cnt becomes 1.
- Both streams continuously valid (reads), o_req_ready=1 → grants alternate I,D,I,D starting with I; 4 requests issued in 4 cycles.
- o_req_ready=0 for 5 cycles with a request buffered → o_req payload stable; both input readys 0; no loss or duplication once ready returns.
- MAX_OUTSTANDING=2, 2 reads issued, no responses → third read stalled (ready 0), while a write on the other stream is still issued. One response → read proceeds.
- o_rsp with tag {1,0x3A} and d_rsp_ready=0 → d_rsp_valid=1, i_rsp_valid=0, o_rsp_ready=0. Raise d_rsp_ready → handshake; cnt decrements; simultaneous new read keeps cnt unchanged.
- Assert rst_i for 1 cycle with a request buffered and cnt=3 → o_req_valid=0, cnt=0, rr=0; idle_o=1 once inputs are idle.
